// File: rtl/hwag_spi_tx_data_frame_if.sv
// Request/response handshake between the rx frame checker and the tx frame builder.
interface hwag_spi_tx_data_frame_if;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic [BYTE_W-1:0] req_cmd;
  logic [BYTE_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              resp_ready;

  modport master (
    output req_valid, req_cmd, req_addr, req_data,
    input  busy, resp_ready
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data,
    output busy, resp_ready
  );
endinterface

// File: rtl/hwag_spi_tx_data_frame.sv
// HWAG SPI transmit frame builder: snapshots a request, computes CRC8 bit-serially,
// and commits [CMD][ADDR][DATA32][CRC] to a tx buffer only while SPI is deselected.
module hwag_spi_tx_data_frame #(
  parameter logic [7:0] CMD_READ = 8'h01
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    spi_ss,
  input  logic                    spi_tx,
  hwag_spi_tx_data_frame_if.slave req,
  output logic [7:0]              rd_addr,
  input  logic [31:0]             rd_data,
  output logic [7:0]              spi_bus_in
);

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned FRAME_BITS = 2 * BYTE_W + DATA_W;
  localparam int unsigned TX_W       = FRAME_BITS + BYTE_W;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned IDX_W      = 3;

  localparam logic [BYTE_W-1:0] CRC_POLY = 8'h07;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    CRC    = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   cmd_q, cmd_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [BYTE_W-1:0]   crc_q, crc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TX_W-1:0]     tx_q, tx_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BYTE_W-1:0]   bus_q, bus_d;
  logic [BYTE_W-1:0]   rd_addr_q, rd_addr_d;
  logic                busy_q, busy_d;
  logic                resp_q, resp_d;

  logic [FRAME_BITS-1:0] work_bits;
  logic                  crc_bit;
  logic                  crc_fb;

  // Byte 0 is the command; index 7 is the overrun slot and reads as zero.
  function automatic logic [BYTE_W-1:0] tx_byte(input logic [TX_W-1:0]  tx_v,
                                                input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    tx_byte = tx_v[55:48];
      3'd1:    tx_byte = tx_v[47:40];
      3'd2:    tx_byte = tx_v[39:32];
      3'd3:    tx_byte = tx_v[31:24];
      3'd4:    tx_byte = tx_v[23:16];
      3'd5:    tx_byte = tx_v[15:8];
      3'd6:    tx_byte = tx_v[7:0];
      default: tx_byte = '0;
    endcase
  endfunction

  assign work_bits = {cmd_q, addr_q, data_q};
  assign crc_bit   = work_bits[LAST_BIT - cnt_q];
  assign crc_fb    = crc_q[BYTE_W-1] ^ crc_bit;

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      crc_q     <= '0;
      cnt_q     <= '0;
      tx_q      <= '0;
      idx_q     <= '0;
      bus_q     <= '0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      idx_q     <= idx_d;
      bus_q     <= bus_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and output logic; a new request always restarts the job.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    resp_d    = 1'b0;

    if (req.req_valid) begin
      cmd_d     = req.req_cmd;
      addr_d    = req.req_addr;
      data_d    = req.req_data;
      rd_addr_d = req.req_addr;
      state_d   = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        FETCH: begin
          if (cmd_q == CMD_READ) begin
            data_d = rd_data;
          end
          crc_d   = '0;
          cnt_d   = '0;
          state_d = CRC;
        end
        CRC: begin
          crc_d = {crc_q[BYTE_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : BYTE_W'(0));
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          // Hold the result until the current frame is over.
          if (spi_ss) begin
            tx_d    = {cmd_q, addr_q, data_q, crc_q};
            resp_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (spi_ss) begin
      idx_d = '0;
    end else if (spi_tx && (idx_q != IDX_MAX)) begin
      idx_d = idx_q + IDX_W'(1);
    end

    bus_d  = tx_byte(tx_d, idx_d);
    busy_d = (state_d != IDLE);
  end

  assign rd_addr        = rd_addr_q;
  assign spi_bus_in     = bus_q;
  assign req.busy       = busy_q;
  assign req.resp_ready = resp_q;

endmodule

// File: tb/tb_hwag_spi_tx_data_frame.sv
// Scoreboard bench for hwag_spi_tx_data_frame: random requests, byte-wise CRC8 model,
// commit timing and SPI frame contents checked against the committed response.
module tb_hwag_spi_tx_data_frame;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        spi_ss = 1'b1;
  logic        spi_tx = 1'b0;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  spi_bus_in;

  hwag_spi_tx_data_frame_if bus();

  hwag_spi_tx_data_frame dut (
    .clk        (clk),
    .nrst       (nrst),
    .spi_ss     (spi_ss),
    .spi_tx     (spi_tx),
    .req        (bus),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .spi_bus_in (spi_bus_in)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Register read mux model.
  logic [31:0] regs [256];
  assign rd_data = regs[rd_addr];

  typedef struct {
    logic [55:0] frame;
    int          t_req;
  } resp_t;

  resp_t       exp_q[$];
  logic [55:0] model_tx = '0;
  int          last_ss_rise = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [7:0] crc8(input logic [7:0] msg[$]);
    logic [7:0] c = 8'h00;
    foreach (msg[i]) begin
      c = c ^ msg[i];
      for (int k = 0; k < 8; k++)
        c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

  function automatic logic [55:0] make_frame(input logic [7:0] cmd, input logic [7:0] addr,
                                             input logic [31:0] data);
    logic [7:0] msg[$];
    msg = '{cmd, addr, data[31:24], data[23:16], data[15:8], data[7:0]};
    return {cmd, addr, data, crc8(msg)};
  endfunction

  function automatic logic [7:0] model_byte(input int pos);
    if (pos >= 7) return 8'h00;
    return model_tx[55 - 8*pos -: 8];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every committed response must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    resp_t e;
    int    t_exp;
    if (nrst && bus.resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got 1 expected 0 (cycle %0d)", cycle);
      end else begin
        e = exp_q.pop_front();
        t_exp = e.t_req + 51;
        if (last_ss_rise + 1 > t_exp) t_exp = last_ss_rise + 1;
        check("resp_latency", 32'(cycle), 32'(t_exp));
        model_tx = e.frame;
      end
    end
  end

  task automatic send_req(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] data);
    resp_t e;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_cmd   = cmd;
    bus.req_addr  = addr;
    bus.req_data  = data;
    e.t_req = cycle;
    e.frame = make_frame(cmd, addr, (cmd == 8'h01) ? regs[addr] : data);
    exp_q.delete();
    exp_q.push_back(e);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_data  = 32'($urandom);
    @(negedge clk);
    check("rd_addr_fetch", 32'(rd_addr), 32'(addr));
    check("busy_fetch", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_commit();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL commit_timeout: got pending %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic lower_ss(input bit with_tx);
    @(posedge clk); #1;
    spi_ss = 1'b0;
    spi_tx = with_tx;
    if (with_tx) begin
      @(posedge clk); #1;
      spi_tx = 1'b0;
    end
  endtask

  task automatic stream(input int pos0, input int n);
    int pos = pos0;
    for (int s = 0; s <= n; s++) begin
      @(negedge clk);
      check($sformatf("byte%0d", pos), 32'(spi_bus_in), 32'(model_byte(pos)));
      if (s < n) begin
        @(posedge clk); #1;
        spi_tx = 1'b1;
        @(posedge clk); #1;
        spi_tx = 1'b0;
        if (pos < 7) pos++;
      end
    end
  endtask

  task automatic raise_ss();
    @(posedge clk); #1;
    spi_ss = 1'b1;
    last_ss_rise = cycle;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("idx_reset_byte0", 32'(spi_bus_in), 32'(model_byte(0)));
  endtask

  task automatic read_frame(input int strobes, input bit with_tx);
    lower_ss(with_tx);
    stream(with_tx ? 1 : 0, with_tx ? strobes - 1 : strobes);
    raise_ss();
  endtask

  initial begin
    logic [7:0] vec[$];
    logic [7:0] c, a;

    bus.req_valid = 1'b0;
    bus.req_cmd   = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    foreach (regs[i]) regs[i] = $urandom;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bus", 32'(spi_bus_in), 32'h0);
    check("rst_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_resp", 32'(bus.resp_ready), 32'h0);
    nrst = 1'b1;

    vec = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    check("model_crc_check_vector", 32'(crc8(vec)), 32'hF4);

    // Write echo, with strobes ignored while deselected
    send_req(8'h00, 8'h00, 32'h0000_0001);
    wait_commit();
    check("echo_frame", model_tx[31:0], 32'h0000_0107);
    repeat (3) begin
      @(posedge clk); #1 spi_tx = 1'b1;
      @(posedge clk); #1 spi_tx = 1'b0;
    end
    @(negedge clk);
    check("tx_ignored_ss_high", 32'(spi_bus_in), 32'(model_byte(0)));
    read_frame(7, 1'b0);

    // Read with rd_data from the mux; ss falls together with the first strobe
    regs[1] = 32'hDEAD_BEEF;
    send_req(8'h01, 8'h01, 32'h1234_5678);
    wait_commit();
    read_frame(7, 1'b1);

    // Random requests
    for (int i = 0; i < 8; i++) begin
      c = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'($urandom);
      a = 8'($urandom);
      send_req(c, a, 32'($urandom));
      wait_commit();
      read_frame(7, 1'($urandom_range(0, 1)));
    end

    // Restart: the second request wins
    send_req(8'h22, 8'h33, 32'hAAAA_5555);
    repeat (18) @(posedge clk);
    send_req(8'h01, 8'h44, 32'h0);
    wait_commit();
    read_frame(7, 1'b0);

    // Commit deferred while a frame is in flight
    lower_ss(1'b0);
    send_req(8'h5A, 8'hC3, 32'h0BAD_F00D);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("busy_deferred", 32'(bus.busy), 32'd1);
    stream(0, 7);
    raise_ss();
    wait_commit();
    read_frame(7, 1'b0);

    // Overrun: nine strobes in one frame
    read_frame(9, 1'b0);

    // Reset mid-CRC discards the job and both buffers
    send_req(8'h01, 8'h10, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    nrst = 1'b0;
    exp_q.delete();
    model_tx = '0;
    #1;
    check("rst_mid_bus", 32'(spi_bus_in), 32'h0);
    check("rst_mid_rd_addr", 32'(rd_addr), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    check("rst_mid_resp", 32'(bus.resp_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (60) @(posedge clk);
    read_frame(7, 1'b0);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwag_spi_tx_data_frame.md
# hwag_spi_tx_data_frame

Transmit-side frame builder for the HWAG SPI link: produces the slave's response stream on `spi_slave.bus_in`, mirroring the receive frame format [CMD8]:[ADDR8]:[DATA32]:[CRC8]. A request accepted in SPI frame N is answered in frame N+1. On each accepted request the block snapshots the command, address and data, computes CRC8 serially, then commits the result to a transmit buffer while SPI is deselected. Sits between `hwag_spi_rx_data_frame` (request source), the register read mux and `spi_slave`.

## Interface
- `CMD_READ`, 8'h01, command code whose response data is fetched from the register read mux.
- `clk`  in  1  system clock.
- `nrst`  in  1  reset, asynchronous, active-low.
- `spi_ss`  in  1  SPI select, active-low, clk-synchronous.
- `spi_tx`  in  1  one-clk strobe from `spi_slave`: current `spi_bus_in` byte has been taken.
- `req_valid`  in  1  one-clk pulse: CRC-checked request accepted (rx `crc_equal & ss_rise`).
- `req_cmd`  in  8  request command.
- `req_addr`  in  8  request address.
- `req_data`  in  32  request data (write payload).
- `rd_addr`  out  8  address to register read mux.
- `rd_data`  in  32  read mux data, valid the cycle after `rd_addr` is stable.
- `spi_bus_in`  out  8  byte presented to `spi_slave.bus_in`.
- `busy`  out  1  response being built or waiting for commit.
- `resp_ready`  out  1  one-clk pulse when a new response is committed.

## Operation
- Work buffer: cmd, addr, data32, crc8. Tx buffer: 7 bytes, byte0=cmd, byte1=addr, bytes2..5=data MSB first, byte6=crc.
- FSM states: IDLE, FETCH, CRC, COMMIT.
  - IDLE: on `req_valid` latch `req_cmd`/`req_addr`/`req_data` into work buffer, drive `rd_addr`=`req_addr`, go FETCH.
  - FETCH (1 clk): if cmd==`CMD_READ` load work data from `rd_data`, else keep `req_data`. Clear crc to 8'h00, clear bit counter, go CRC.
  - CRC (48 clk): one bit per clk, MSB first, order cmd, addr, data[31:24]..data[7:0]. Poly 0x07, init 0x00, no reflection, no final XOR: fb=crc[7]^bit; crc={crc[6:0],0}^(fb?8'h07:8'h00). After bit 47 go COMMIT.
  - COMMIT: wait until `spi_ss`=1; in that cycle copy work buffer into tx buffer, pulse `resp_ready`, go IDLE.
- `req_valid` in any non-IDLE state: abort current job, latch the new request, go FETCH (latest request wins).
- `busy`=1 in FETCH, CRC and COMMIT.
- Byte index idx (3 bit): held at 0 while `spi_ss`=1. While `spi_ss`=0, each `spi_tx` increments idx, saturating at 7.
- `spi_bus_in` = tx buffer[idx] for idx 0..6, 8'h00 for idx 7.
- Tx buffer never changes while `spi_ss`=0, so a frame in flight always carries one consistent response.

## Timing
- Reset (`nrst`=0, async): FSM=IDLE, work and tx buffers=0, idx=0, `spi_bus_in`=8'h00, `rd_addr`=8'h00, `busy`=0, `resp_ready`=0. Reset mid-job or mid-frame discards everything.
- Latency `req_valid` to `resp_ready`: 1 (IDLE→FETCH) + 1 (FETCH) + 48 (CRC) + 1 (COMMIT) = 51 clk when `spi_ss` stays high. Longer by however long `spi_ss` is low at COMMIT entry.
- `spi_bus_in` is registered: updates the clk after the `spi_tx` strobe, and the clk after `spi_ss` rises (idx→0).
- `spi_tx` while `spi_ss`=1: ignored.
- `spi_ss` falling and `spi_tx` in the same clk: the strobe counts.
- `rd_data` is sampled exactly once, in FETCH.

## Test plan
- Reset: assert `nrst`=0 mid-CRC → all outputs 0. Then a 7-byte frame returns seven 8'h00 bytes (CRC of zeros = 8'h00).
- Write echo: `req_valid` with cmd=8'h00, addr=8'h00, data=32'h00000001, `spi_ss` high. Required: `resp_ready` exactly 51 clk later; next frame bytes 00,00,00,00,00,01,07.
- Read: cmd=8'h01, addr=8'h01, `rd_data`=32'hDEADBEEF. Required: `rd_addr`=8'h01 during FETCH; frame bytes 01,01,DE,AD,BE,EF,crc, where crc matches the bench CRC8 (0x07) model; the "123456789" check vector gives F4.
- Commit deferral: hold `spi_ss`=0 across CRC completion. Required: `busy`=1 and old response still streamed; commit plus `resp_ready` on the first clk with `spi_ss`=1.
- Restart: second `req_valid` 20 clk after the first. Required: only one `resp_ready`, 51 clk after the second; the frame carries the second request.
- Overrun: 9 `spi_tx` strobes in one frame. Required: bytes 0..6 from the buffer, then 8'h00 twice; idx returns to 0 after `spi_ss` rises.
